// File: rtl/mem_dump_tx_pkg.sv
// Shared constants for the program-RAM dump transmitter: UART framing,
// RAM access encodings and FSM state codes.
package mem_dump_tx_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int unsigned FRAME_BITS = 10;

    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_RD_REQ  = 3'd1;
    localparam state_t S_RD_WAIT = 3'd2;
    localparam state_t S_LATCH   = 3'd3;
    localparam state_t S_SEND_HI = 3'd4;
    localparam state_t S_SEND_LO = 3'd5;
    localparam state_t S_FIN     = 3'd6;

    // Select the high or low byte of a 16-bit RAM word.
    function automatic logic [7:0] byte_of(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter; bit timing is counted in ce-qualified cycles.
// byte_done is high during the final ce-cycle of the stop bit so a new
// byte can be chained without an idle gap.
module uart_tx_byte
    import mem_dump_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = $clog2(FRAME_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);

    logic              busy_q, busy_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [8:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              byte_done_q, byte_done_d;
    logic              last_c;

    assign last_c = busy_q && (bit_cnt_q == BIT_LAST) && (baud_cnt_q == BAUD_LAST);

    // Frame sequencing: shift register holds the remaining data bits plus stop bit.
    always_comb begin
        busy_d     = busy_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        if (start && (!busy_q || last_c)) begin
            busy_d     = 1'b1;
            bit_cnt_d  = '0;
            baud_cnt_d = '0;
            shift_d    = {STOP_BIT, data};
            tx_d       = START_BIT;
        end else if (busy_q) begin
            if (baud_cnt_q == BAUD_LAST) begin
                baud_cnt_d = '0;
                if (bit_cnt_q == BIT_LAST) begin
                    busy_d = 1'b0;
                    tx_d   = STOP_BIT;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    tx_d      = shift_q[0];
                    shift_d   = {STOP_BIT, shift_q[8:1]};
                end
            end else begin
                baud_cnt_d = baud_cnt_q + BAUD_W'(1);
            end
        end
        byte_done_d = busy_d && (bit_cnt_d == BIT_LAST) && (baud_cnt_d == BAUD_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= 1'b0;
            bit_cnt_q   <= '0;
            baud_cnt_q  <= '0;
            shift_q     <= '1;
            tx_q        <= STOP_BIT;
            byte_done_q <= 1'b0;
        end else if (ce) begin
            busy_q      <= busy_d;
            bit_cnt_q   <= bit_cnt_d;
            baud_cnt_q  <= baud_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            byte_done_q <= byte_done_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign byte_done = byte_done_q;

endmodule

// File: rtl/mem_dump_tx.sv
// Streams the program RAM out over UART: reads words 0..LAST_ADDR and sends
// each as two 8N1 bytes, MSB byte first.
module mem_dump_tx
    import mem_dump_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned LAST_ADDR    = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              scan_start,
    input  logic [DATA_W-1:0] ram_out,
    output logic [ADDR_W-1:0] ram_adr,
    output logic              ram_enable,
    output logic              ram_rw,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ram_enable_q, ram_enable_d;

    logic              tx_start_c;
    logic [7:0]        tx_data_c;
    logic              tx_busy;
    logic              tx_byte_done;

    // Scan sequencing: fetch a word, send hi byte, chain lo byte, advance.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        word_d       = word_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        ram_enable_d = 1'b0;
        tx_start_c   = 1'b0;
        tx_data_c    = byte_of(word_q, 1'b0);
        case (state_q)
            S_IDLE: begin
                if (scan_start) begin
                    state_d      = S_RD_REQ;
                    addr_d       = '0;
                    busy_d       = 1'b1;
                    ram_enable_d = 1'b1;
                end
            end
            S_RD_REQ:  state_d = S_RD_WAIT;
            S_RD_WAIT: state_d = S_LATCH;
            S_LATCH: begin
                word_d = ram_out;
                if (!tx_busy) begin
                    tx_start_c = 1'b1;
                    tx_data_c  = byte_of(ram_out, 1'b1);
                    state_d    = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                if (tx_byte_done) begin
                    tx_start_c = 1'b1;
                    state_d    = S_SEND_LO;
                end
            end
            S_SEND_LO: begin
                if (tx_byte_done) begin
                    if (addr_q == ADDR_LAST) begin
                        state_d = S_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        addr_d       = addr_q + ADDR_W'(1);
                        state_d      = S_RD_REQ;
                        ram_enable_d = 1'b1;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            word_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ram_enable_q <= 1'b0;
        end else if (ce) begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            word_q       <= word_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ram_enable_q <= ram_enable_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .start    (tx_start_c),
        .data     (tx_data_c),
        .tx       (tx),
        .busy     (tx_busy),
        .byte_done(tx_byte_done)
    );

    assign ram_adr    = addr_q;
    assign ram_enable = ram_enable_q;
    assign ram_rw     = RAM_READ;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Directed bench for mem_dump_tx: a 64-word instance and a single-word
// instance share clk/rst/ce; a UART decoder watches the selected tx line.
module tb_mem_dump_tx;

    localparam int unsigned C = 4;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic ce_mode = 1'b0;
    logic ce_tog  = 1'b0;
    logic ce;
    assign ce = ce_mode ? ce_tog : 1'b1;

    logic        scan_full, scan_one;
    logic [15:0] ram_out_full, ram_out_one;
    logic [5:0]  ram_adr_full, ram_adr_one;
    logic        ram_en_full, ram_en_one, ram_rw_full, ram_rw_one;
    logic        tx_full, tx_one, busy_full, busy_one, done_full, done_one;

    logic [15:0] mem_full [64];
    logic [15:0] mem_one  [64];

    int checks   = 0;
    int failures = 0;

    mem_dump_tx #(.CLKS_PER_BIT(C), .ADDR_W(6), .DATA_W(16), .LAST_ADDR(63)) u_full (
        .clk(clk), .rst(rst), .ce(ce), .scan_start(scan_full), .ram_out(ram_out_full),
        .ram_adr(ram_adr_full), .ram_enable(ram_en_full), .ram_rw(ram_rw_full),
        .tx(tx_full), .busy(busy_full), .done(done_full));

    mem_dump_tx #(.CLKS_PER_BIT(C), .ADDR_W(6), .DATA_W(16), .LAST_ADDR(0)) u_one (
        .clk(clk), .rst(rst), .ce(ce), .scan_start(scan_one), .ram_out(ram_out_one),
        .ram_adr(ram_adr_one), .ram_enable(ram_en_one), .ram_rw(ram_rw_one),
        .tx(tx_one), .busy(busy_one), .done(done_one));

    always #5 clk = ~clk;
    always @(posedge clk) begin #1; ce_tog = ~ce_tog; end

    // Synchronous RAM models: data valid one ce-cycle after the enable cycle.
    always @(posedge clk) begin
        if (ce && ram_en_full) ram_out_full <= mem_full[ram_adr_full];
        if (ce && ram_en_one)  ram_out_one  <= mem_one[ram_adr_one];
    end

    logic sel_one = 1'b0;
    logic mon_tx, mon_busy;
    assign mon_tx   = sel_one ? tx_one   : tx_full;
    assign mon_busy = sel_one ? busy_one : busy_full;

    logic [7:0] rx_q [$];
    logic [5:0] adr_q [$];
    logic [9:0] fb;
    logic       in_frame  = 1'b0;
    logic       gap_valid = 1'b0;
    int k = 0, ncyc = 0, span_start = 0, gap = 0, gap_max = 0;
    int span_min = 1000000, span_max = 0;
    int width_err = 0, frame_err = 0, rw_err = 0;
    int done_full_cnt = 0, done_one_cnt = 0;
    logic done_full_p = 1'b0, done_one_p = 1'b0;

    // UART decoder in ce-cycles; span = clk cycles from start bit to stop bit.
    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            in_frame  = 1'b0;
            gap_valid = 1'b0;
        end else if (ce) begin
            if (!in_frame) begin
                if (mon_tx === 1'b0) begin
                    if (gap_valid && gap > gap_max) gap_max = gap;
                    in_frame   = 1'b1;
                    k          = 0;
                    span_start = ncyc;
                end else begin
                    gap++;
                    if (!mon_busy) gap_valid = 1'b0;
                end
            end
            if (in_frame) begin
                if (k % C == 0) fb[k / C] = mon_tx;
                else if (mon_tx !== fb[k / C]) width_err++;
                if (k == 9 * C) begin
                    if (ncyc - span_start < span_min) span_min = ncyc - span_start;
                    if (ncyc - span_start > span_max) span_max = ncyc - span_start;
                end
                if (k == 10 * C - 1) begin
                    in_frame = 1'b0;
                    if (fb[9] !== 1'b1) frame_err++;
                    rx_q.push_back(fb[8:1]);
                    gap       = 0;
                    gap_valid = 1'b1;
                end else begin
                    k++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done_full && !done_full_p) done_full_cnt++;
        if (done_one && !done_one_p)   done_one_cnt++;
        done_full_p = done_full;
        done_one_p  = done_one;
        if (ce && ram_en_full) adr_q.push_back(ram_adr_full);
        if (ram_rw_full !== 1'b0 || ram_rw_one !== 1'b0) rw_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        adr_q.delete();
        width_err = 0; frame_err = 0; gap_max = 0; gap_valid = 1'b0;
        span_min = 1000000; span_max = 0;
        done_full_cnt = 0; done_one_cnt = 0;
    endtask

    task automatic wait_done(input logic one, input int bound, input string tag);
        int n = 0;
        while (((one ? done_one : done_full) !== 1'b1) && n < bound) begin
            @(posedge clk); #1; n++;
        end
        chk(tag, one ? done_one : done_full, 1'b1);
    endtask

    task automatic wait_bytes(input int cnt, input int bound, input string tag);
        int n = 0;
        while (rx_q.size() < cnt && n < bound) begin
            @(posedge clk); #1; n++;
        end
        chk(tag, (rx_q.size() >= cnt), 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int byte_err;
        int adr_err;
        logic [7:0] exp_b;
        for (int i = 0; i < 64; i++) begin
            mem_full[i] = 16'(i * 16'h0101 + 16'h1000);
            mem_one[i]  = 16'h0000;
        end
        mem_one[0] = 16'hA55A;
        scan_full  = 1'b0;
        scan_one   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx_full, 1'b1);
        chk("rst_busy", busy_full, 1'b0);
        chk("rst_done", done_full, 1'b0);
        chk("rst_ram_enable", ram_en_full, 1'b0);
        chk("rst_ram_adr", ram_adr_full, 6'd0);
        chk("rst_ram_rw", ram_rw_full, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single word A55A: first start bit 4 ce-cycles after scan_start is sampled
        sel_one = 1'b1;
        clear_mon();
        scan_one = 1'b1;
        lat = 0;
        while (tx_one !== 1'b0 && lat < 20) begin
            @(posedge clk); #1; lat++;
            if (lat == 1) scan_one = 1'b0;
        end
        chk("first_start_latency", lat, 4);
        wait_done(1'b1, 300, "one_done_seen");
        repeat (3) @(posedge clk);
        #1;
        chk("one_byte_count", rx_q.size(), 2);
        if (rx_q.size() >= 2) begin
            chk("one_byte_hi", rx_q[0], 8'hA5);
            chk("one_byte_lo", rx_q[1], 8'h5A);
        end
        chk("one_done_pulses", done_one_cnt, 1);
        chk("one_busy_after", busy_one, 1'b0);
        chk("one_bit_width", width_err, 0);
        chk("one_stop_bits", frame_err, 0);
        chk("one_span_min", span_min, 9 * C);
        chk("one_span_max", span_max, 9 * C);
        chk("one_hi_lo_gap", gap_max, 0);

        // Reset mid-frame on the full instance
        sel_one = 1'b0;
        clear_mon();
        scan_full = 1'b1;
        @(posedge clk); #1;
        scan_full = 1'b0;
        wait_bytes(1, 300, "midrst_first_byte");
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_in_frame_tx", tx_full, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_tx", tx_full, 1'b1);
        chk("midrst_busy", busy_full, 1'b0);
        chk("midrst_ram_enable", ram_en_full, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("midrst_no_more_bytes", rx_q.size(), 1);
        chk("midrst_single_read", adr_q.size(), 1);
        chk("midrst_tx_idle", tx_full, 1'b1);
        chk("midrst_busy_idle", busy_full, 1'b0);

        // Full dump with scan_start re-asserted while busy
        clear_mon();
        scan_full = 1'b1;
        @(posedge clk); #1;
        scan_full = 1'b0;
        wait_bytes(5, 600, "full_reach_byte5");
        scan_full = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        scan_full = 1'b0;
        wait_done(1'b0, 9000, "full_done_seen");
        repeat (60) @(posedge clk);
        #1;
        chk("full_byte_count", rx_q.size(), 128);
        byte_err = 0;
        for (int i = 0; i < rx_q.size() && i < 128; i++) begin
            exp_b = (i % 2 == 0) ? 8'(8'h10 + i / 2) : 8'(i / 2);
            if (rx_q[i] !== exp_b) byte_err++;
        end
        chk("full_byte_errors", byte_err, 0);
        if (rx_q.size() == 128) begin
            chk("full_byte0", rx_q[0], 8'h10);
            chk("full_byte1", rx_q[1], 8'h00);
            chk("full_byte126", rx_q[126], 8'h4F);
            chk("full_byte127", rx_q[127], 8'h3F);
        end
        chk("full_read_count", adr_q.size(), 64);
        adr_err = 0;
        for (int i = 0; i < adr_q.size() && i < 64; i++)
            if (adr_q[i] !== 6'(i)) adr_err++;
        chk("full_addr_order", adr_err, 0);
        chk("full_ram_rw_zero", rw_err, 0);
        chk("full_done_pulses", done_full_cnt, 1);
        chk("full_busy_after", busy_full, 1'b0);
        chk("full_gap_le3", (gap_max <= 3), 1'b1);
        chk("full_bit_width", width_err, 0);
        chk("full_stop_bits", frame_err, 0);
        chk("full_span_max", span_max, 9 * C);

        // ce alternating: each bit spans 2*C clk cycles
        sel_one = 1'b1;
        clear_mon();
        ce_mode  = 1'b1;
        scan_one = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        scan_one = 1'b0;
        wait_done(1'b1, 600, "ce_done_seen");
        repeat (4) @(posedge clk);
        #1;
        ce_mode = 1'b0;
        chk("ce_byte_count", rx_q.size(), 2);
        if (rx_q.size() >= 2) begin
            chk("ce_byte_hi", rx_q[0], 8'hA5);
            chk("ce_byte_lo", rx_q[1], 8'h5A);
        end
        chk("ce_span_min", span_min, 18 * C);
        chk("ce_span_max", span_max, 18 * C);
        chk("ce_bit_width", width_err, 0);
        chk("ce_done_pulses", done_one_cnt, 1);

        // scan_start held through FIN restarts right after IDLE
        repeat (2) @(posedge clk);
        #1;
        clear_mon();
        scan_one = 1'b1;
        wait_done(1'b1, 300, "hold_done1_seen");
        @(posedge clk); #1;
        chk("hold_idle_busy", busy_one, 1'b0);
        chk("hold_idle_done", done_one, 1'b0);
        @(posedge clk); #1;
        chk("hold_restart_busy", busy_one, 1'b1);
        scan_one = 1'b0;
        wait_done(1'b1, 300, "hold_done2_seen");
        repeat (3) @(posedge clk);
        #1;
        chk("hold_byte_count", rx_q.size(), 4);
        if (rx_q.size() >= 4) begin
            chk("hold_byte2", rx_q[2], 8'hA5);
            chk("hold_byte3", rx_q[3], 8'h5A);
        end
        chk("hold_done_pulses", done_one_cnt, 2);
        chk("final_ram_rw_zero", rw_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_dump_tx.md
Name: mem_dump_tx

Overview:
- Read-back counterpart of the boot loader: the boot loader receives an image over UART and writes it into the 64x16 program RAM; this block reads that RAM and streams it out over UART TX.
- On a scan request it walks addresses 0..LAST_ADDR, reads each 16-bit word, and transmits it as two 8N1 bytes, MSB byte first.
- Sits beside the boot loader in the top level, sharing the RAM port (ram_adr/ram_enable/ram_rw/ram_out) and driving the tx pin. The top-level arbiter grants the RAM while busy=1.

Parameters:
- CLKS_PER_BIT, 434, ce-qualified clocks per UART bit (50 MHz / 115200).
- ADDR_W, 6, RAM address width.
- DATA_W, 16, RAM word width; fixed at 2 bytes.
- LAST_ADDR, 63, final address dumped.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ce  in  1  clock enable; when 0, all state, counters and outputs hold
- scan_start  in  1  level/pulse request; sampled only in IDLE
- ram_out  in  DATA_W  RAM read data, valid one ce-cycle after the enable cycle
- ram_adr  out  ADDR_W  RAM address
- ram_enable  out  1  RAM access strobe, one cycle per word
- ram_rw  out  1  0 = read; tied 0 by this block
- tx  out  1  UART serial out, idle high
- busy  out  1  high from scan acceptance until the last stop bit completes
- done  out  1  one-ce-cycle pulse after the final byte

Behaviour:
- Reset (async, rst=1): state IDLE, tx=1, busy=0, done=0, ram_enable=0, ram_rw=0, ram_adr=0, bit and baud counters 0.
- All transitions below occur only on clk edges with ce=1.
- FSM states:
  - IDLE: if scan_start=1, go to RD_REQ with addr=0 and busy=1.
  - RD_REQ: ram_enable=1, ram_adr=addr (one cycle); go to RD_WAIT.
  - RD_WAIT: ram_enable=0; go to LATCH.
  - LATCH: word_reg<=ram_out; start byte word_reg[15:8]; go to SEND_HI.
  - SEND_HI: when the byte completes, start byte word_reg[7:0]; go to SEND_LO.
  - SEND_LO: when the byte completes, if addr==LAST_ADDR go to FIN; else addr+1, go to RD_REQ.
  - FIN: done=1 for one cycle, busy=0; go to IDLE.
- UART frame: start bit 0, data bits LSB first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT ce-cycles. Frame = 10*CLKS_PER_BIT ce-cycles.
- The next start bit may be separated from the previous stop bit by at most 3 ce-cycles (RAM fetch gap); tx stays 1 during the gap.
- Address does not wrap: the counter stops at LAST_ADDR. Total bytes per scan = 2*(LAST_ADDR+1) = 128.
- scan_start while busy=1 is ignored; there is no queueing. scan_start held high through FIN restarts the scan on the cycle after return to IDLE.
- ce=0 mid-bit freezes the baud counter; bit width is counted in ce-cycles only.
- Reset mid-frame: tx returns to 1 immediately (async) and no partial resumption occurs.
- ram_out is sampled only in LATCH; changes at any other time are ignored.

Decomposition:
- Shared package holds: UART frame constants (START_BIT=0, STOP_BIT=1, FRAME_BITS=10), RAM_READ=0 / RAM_WRITE=1 encodings, and the FSM state enumeration.
- One sub-module, uart_tx_byte:
  - Inputs: clk, rst, ce, start, data[7:0].
  - Outputs: tx, busy, byte_done (one-cycle pulse).
  - Owns the baud counter and bit counter.
- mem_dump_tx owns the FSM, address counter and word register.

Test Plan:
- Reset: rst=1 asynchronously mid-frame -> tx=1, busy=0, ram_enable=0 within the same cycle; no further bytes emitted.
- Single word, LAST_ADDR=0, CLKS_PER_BIT=4, RAM[0]=0xA55A:
  - tx shows 0xA5 then 0x5A, each 0,LSB..MSB,1 with 4-cycle bits.
  - done pulses once; busy=0 afterwards.
- Full dump, RAM[i]=i*0x0101+0x1000, LAST_ADDR=63:
  - exactly 128 bytes decoded in address order, MSB first.
  - ram_enable pulses 64 times with ram_adr=0..63 and ram_rw=0 throughout.
- scan_start re-asserted at byte 5 while busy -> ignored; byte count remains 128 with a single done pulse.
- ce toggled 1/0 every other cycle -> every bit measures 2*CLKS_PER_BIT clk cycles; decoded data unchanged.
- Gap check: inter-frame idle between consecutive bytes is ≤3 ce-cycles with tx=1; first start bit occurs within 4 ce-cycles of scan_start.
